// File: rtl/atomic_counter_reader.sv
// ---------------------------------------------------------------------------
// atomic_counter_reader
//
// Takes coherent 64-bit snapshots of a 64-bit counter that exposes a 32-bit
// read port. Each snapshot starts with an atomic low-word read. The counter
// latches its upper half at that moment. A plain high-word read follows and
// returns the latched half. The two words are joined and queued in a small
// FIFO that drains over a valid/ready stream.
//
// Optional feature (macro ATOMIC_COUNTER_READER_TIMEOUT_EN):
//   If the counter fails to ack within TIMEOUT consecutive wait cycles, the
//   sequence is aborted and timeout_o pulses. Without the macro the wait
//   states wait forever and timeout_o is tied low.
//
// Parameters:
//   DEPTH   - snapshot FIFO entries (power of two, >= 2)
//   TIMEOUT - max consecutive ack-less wait cycles (1..255)
//
// Ports:
//   clk          - clock, rising edge
//   reset        - asynchronous active-low reset
//   sample_i     - single-cycle snapshot request
//   busy_o       - read sequence in flight
//   drop_o       - registered pulse: a sample_i was not accepted
//   timeout_o    - registered pulse: a sequence was aborted
//   cnt_req_o    - counter read request
//   cnt_atomic_o - request is the atomic low-word read
//   cnt_ack_i    - counter read acknowledge
//   cnt_data_i   - counter read data, valid with cnt_ack_i
//   snap_valid_o - FIFO head valid
//   snap_ready_i - consumer accepts FIFO head
//   snap_data_o  - FIFO head {high word, low word}
//   snap_count_o - FIFO occupancy
// ---------------------------------------------------------------------------
module atomic_counter_reader #(
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 15
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   sample_i,
   output logic                   busy_o,
   output logic                   drop_o,
   output logic                   timeout_o,
   output logic                   cnt_req_o,
   output logic                   cnt_atomic_o,
   input  logic                   cnt_ack_i,
   input  logic [31:0]            cnt_data_i,
   output logic                   snap_valid_o,
   input  logic                   snap_ready_i,
   output logic [63:0]            snap_data_o,
   output logic [$clog2(DEPTH):0] snap_count_o
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

   typedef enum logic [2:0] {
      IDLE,
      REQ_LO,
      WAIT_LO,
      REQ_HI,
      WAIT_HI
   } state_t;

   state_t        state;
   state_t        next_state;

   logic [31:0]   lo_word;
   logic [63:0]   mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;

   logic          drop_q;
   logic          drop_next;
   logic          lo_load;
   logic          push;
   logic          pop;
   logic          wait_expire;

   // Legal parameter space: DEPTH a power of two >= 2, TIMEOUT in 1..255.
   // The pointer arithmetic below relies on DEPTH being a power of two.
   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1 || TIMEOUT > 255) begin : g_param_out_of_range
   end

`ifdef ATOMIC_COUNTER_READER_TIMEOUT_EN
   localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

   logic [7:0] wait_cnt;
   logic       timeout_q;
   logic       in_wait;

   assign in_wait     = (state == WAIT_LO) || (state == WAIT_HI);
   assign wait_expire = in_wait && !cnt_ack_i && (wait_cnt == WAIT_LAST);

   // Counts consecutive ack-less wait cycles. Any exit from a wait state
   // (ack or abort) clears it, so the high-word wait starts from zero.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wait_cnt <= '0;
      end else if (in_wait && !cnt_ack_i && !wait_expire) begin
         wait_cnt <= wait_cnt + 8'd1;
      end else begin
         wait_cnt <= '0;
      end
   end

   // The abort pulse is visible in the first IDLE cycle after the abort.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         timeout_q <= 1'b0;
      end else begin
         timeout_q <= wait_expire;
      end
   end

   assign timeout_o = timeout_q;
`else
   assign wait_expire = 1'b0;
   assign timeout_o   = 1'b0;
`endif

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic. FIFO space is reserved when a sample is accepted,
   // which is why the WAIT_HI push never needs a full check. The high-word
   // request is only reached after the low-word ack. That ordering makes
   // the counter's latched upper half match the low word.
   always_comb begin
      next_state = state;
      drop_next  = 1'b0;
      lo_load    = 1'b0;
      push       = 1'b0;
      case (state)
         IDLE: begin
            if (sample_i) begin
               if (count < FULL_COUNT) begin
                  next_state = REQ_LO;
               end else begin
                  drop_next = 1'b1;
               end
            end
         end
         REQ_LO: begin
            next_state = WAIT_LO;
         end
         WAIT_LO: begin
            if (cnt_ack_i) begin
               lo_load    = 1'b1;
               next_state = REQ_HI;
            end else if (wait_expire) begin
               next_state = IDLE;
            end
         end
         REQ_HI: begin
            next_state = WAIT_HI;
         end
         WAIT_HI: begin
            if (cnt_ack_i) begin
               push       = 1'b1;
               next_state = IDLE;
            end else if (wait_expire) begin
               next_state = IDLE;
            end
         end
         default: begin
            next_state = IDLE;
         end
      endcase
      if (sample_i && state != IDLE) begin
         drop_next = 1'b1;
      end
   end

   // Moore outputs, decoded from state only.
   assign busy_o       = (state != IDLE);
   assign cnt_req_o    = (state == REQ_LO) || (state == REQ_HI);
   assign cnt_atomic_o = (state == REQ_LO);

   // Registered drop pulse and the low-word holding register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         drop_q  <= 1'b0;
         lo_word <= '0;
      end else begin
         drop_q <= drop_next;
         if (lo_load) begin
            lo_word <= cnt_data_i;
         end
      end
   end

   assign drop_o = drop_q;

   // Snapshot FIFO. Storage is cleared on reset so the head reads 0 out of
   // reset. Pointers wrap naturally because DEPTH is a power of two.
   assign pop = snap_valid_o && snap_ready_i;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (push) begin
            mem[wr_ptr] <= {cnt_data_i, lo_word};
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   assign snap_valid_o = (count != '0);
   assign snap_data_o  = mem[rd_ptr];
   assign snap_count_o = count;

endmodule

// File: tb/tb_atomic_counter_reader.sv
// ---------------------------------------------------------------------------
// tb_atomic_counter_reader
//
// Drives atomic_counter_reader with a behavioural 64-bit counter. The counter
// value at cycle t is CNT_BASE + t*CNT_STEP. An atomic read latches the whole
// value and returns the low half. The next plain read returns the latched
// high half. The counter acks one cycle after each request.
// Directed sequences cover the corner cases. A randomized run is checked
// against a cycle-level model of sample acceptance, drops and FIFO contents.
// ---------------------------------------------------------------------------
module tb_atomic_counter_reader;

   localparam int DEPTH   = 4;
   localparam int TIMEOUT = 15;
   localparam int CW      = $clog2(DEPTH) + 1;
   localparam logic [63:0] CNT_BASE = 64'h0000_0007_FFFF_FF80;
   localparam logic [63:0] CNT_STEP = 64'h0000_0001_0000_0013;

   logic          clk;
   logic          reset;
   logic          sample_i;
   logic          busy_o;
   logic          drop_o;
   logic          timeout_o;
   logic          cnt_req_o;
   logic          cnt_atomic_o;
   logic          cnt_ack_i;
   logic [31:0]   cnt_data_i;
   logic          snap_valid_o;
   logic          snap_ready_i;
   logic [63:0]   snap_data_o;
   logic [CW-1:0] snap_count_o;

   int            checks;
   int            failures;
   int            cyc;
   logic          ack_en;
   logic          stray_en;
   logic [63:0]   latch;
   logic [31:0]   override_q [$];

   typedef struct {
      logic        sample;
      logic        ready;
      logic        req;
      logic        atomic;
      logic        busy;
      logic        valid;
      logic [3:0]  count;
      logic        chk_data;
      logic [63:0] data;
   } vec_t;

   vec_t vecs [8];

   atomic_counter_reader #(
      .DEPTH   (DEPTH),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .sample_i     (sample_i),
      .busy_o       (busy_o),
      .drop_o       (drop_o),
      .timeout_o    (timeout_o),
      .cnt_req_o    (cnt_req_o),
      .cnt_atomic_o (cnt_atomic_o),
      .cnt_ack_i    (cnt_ack_i),
      .cnt_data_i   (cnt_data_i),
      .snap_valid_o (snap_valid_o),
      .snap_ready_i (snap_ready_i),
      .snap_data_o  (snap_data_o),
      .snap_count_o (snap_count_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hard stop in case anything stalls.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic logic [63:0] cnt_at(input int t);
      return CNT_BASE + (64'(t) * CNT_STEP);
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   // Advance one cycle. Inputs change 1ns after the rising edge. The counter
   // model answers a request seen in the previous cycle.
   task automatic tick();
      logic req_seen;
      logic atomic_seen;
      req_seen    = cnt_req_o;
      atomic_seen = cnt_atomic_o;
      @(posedge clk);
      #1;
      cyc++;
      sample_i   = 1'b0;
      cnt_ack_i  = 1'b0;
      cnt_data_i = $urandom;
      if (req_seen && ack_en) begin
         cnt_ack_i = 1'b1;
         if (atomic_seen) begin
            latch      = cnt_at(cyc);
            cnt_data_i = latch[31:0];
         end else begin
            cnt_data_i = latch[63:32];
         end
         if (override_q.size() > 0) begin
            cnt_data_i = override_q.pop_front();
         end
      end else if (stray_en && $urandom_range(0, 7) == 0) begin
         cnt_ack_i = 1'b1;
      end
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_busy"},   64'(busy_o),       64'd0);
      checkOutput({tag, "_drop"},   64'(drop_o),       64'd0);
      checkOutput({tag, "_tmo"},    64'(timeout_o),    64'd0);
      checkOutput({tag, "_req"},    64'(cnt_req_o),    64'd0);
      checkOutput({tag, "_atomic"}, 64'(cnt_atomic_o), 64'd0);
      checkOutput({tag, "_valid"},  64'(snap_valid_o), 64'd0);
      checkOutput({tag, "_count"},  64'(snap_count_o), 64'd0);
      checkOutput({tag, "_data"},   snap_data_o,       64'd0);
   endtask

   task automatic drain();
      snap_ready_i = 1'b1;
      repeat (DEPTH + 1) tick();
      snap_ready_i = 1'b0;
   endtask

   // Randomized traffic against a model built from the acceptance rules and
   // the fixed 5-cycle latency. A sample accepted in cycle t keeps the block
   // busy through t+4. It requests in t+1 (atomic) and t+3. It pushes
   // cnt_at(t+2) at the end of t+4.
   task automatic applyStimulus(input int n_cycles);
      int          busy_end;
      int          push_at;
      int          start_size;
      logic [63:0] push_val;
      logic        drop_exp;
      logic        busy_exp;
      logic [63:0] exp_q [$];
      busy_end = cyc - 1;
      push_at  = -1;
      push_val = '0;
      drop_exp = 1'b0;
      stray_en = 1'b1;
      for (int n = 0; n < n_cycles; n++) begin
         sample_i     = ($urandom_range(0, 3) == 0);
         snap_ready_i = ($urandom_range(0, 2) != 0);
         busy_exp     = (cyc <= busy_end);
         checkOutput("rnd_busy",  64'(busy_o),       64'(busy_exp));
         checkOutput("rnd_drop",  64'(drop_o),       64'(drop_exp));
         checkOutput("rnd_tmo",   64'(timeout_o),    64'd0);
         checkOutput("rnd_req",   64'(cnt_req_o),    64'(busy_exp && (cyc == busy_end - 3 || cyc == busy_end - 1)));
         checkOutput("rnd_atom",  64'(cnt_atomic_o), 64'(busy_exp && (cyc == busy_end - 3)));
         checkOutput("rnd_count", 64'(snap_count_o), 64'(exp_q.size()));
         checkOutput("rnd_valid", 64'(snap_valid_o), 64'(exp_q.size() != 0));
         if (exp_q.size() != 0) begin
            checkOutput("rnd_data", snap_data_o, exp_q[0]);
         end
         start_size = exp_q.size();
         if (snap_ready_i && exp_q.size() != 0) begin
            void'(exp_q.pop_front());
         end
         if (cyc == push_at) begin
            exp_q.push_back(push_val);
         end
         drop_exp = 1'b0;
         if (sample_i) begin
            if (cyc > busy_end && start_size < DEPTH) begin
               busy_end = cyc + 4;
               push_at  = cyc + 4;
               push_val = cnt_at(cyc + 2);
            end else begin
               drop_exp = 1'b1;
            end
         end
         tick();
      end
      stray_en = 1'b0;
   endtask

   initial begin
      int          t0;
      int          t1;
      int          acc [4];
      int          busy_low;
      logic [63:0] pre_count;

      checks       = 0;
      failures     = 0;
      cyc          = 0;
      ack_en       = 1'b1;
      stray_en     = 1'b0;
      latch        = '0;
      sample_i     = 1'b0;
      snap_ready_i = 1'b0;
      cnt_ack_i    = 1'b0;
      cnt_data_i   = '0;
      reset        = 1'b1;

      vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 64'h0};
      vecs[1] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 64'h0};
      vecs[2] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 64'h0};
      vecs[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 64'h0};
      vecs[4] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 64'h0};
      vecs[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd1, 1'b1, 64'h0000_0002_FFFF_FFFF};
      vecs[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd1, 1'b1, 64'h0000_0002_FFFF_FFFF};
      vecs[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 64'h0};

      // Power-on reset.
      #2 reset = 1'b0;
      tick();
      tick();
      checkAllZero("por");
      reset = 1'b1;
      tick();
      tick();

      // Single sample with forced counter words.
      $display("[TB] single sample table");
      override_q.push_back(32'hFFFF_FFFF);
      override_q.push_back(32'h0000_0002);
      for (int i = 0; i < 8; i++) begin
         sample_i     = vecs[i].sample;
         snap_ready_i = vecs[i].ready;
         checkOutput($sformatf("vec%0d_req", i),    64'(cnt_req_o),    64'(vecs[i].req));
         checkOutput($sformatf("vec%0d_atomic", i), 64'(cnt_atomic_o), 64'(vecs[i].atomic));
         checkOutput($sformatf("vec%0d_busy", i),   64'(busy_o),       64'(vecs[i].busy));
         checkOutput($sformatf("vec%0d_valid", i),  64'(snap_valid_o), 64'(vecs[i].valid));
         checkOutput($sformatf("vec%0d_count", i),  64'(snap_count_o), 64'(vecs[i].count));
         if (vecs[i].chk_data) begin
            checkOutput($sformatf("vec%0d_data", i), snap_data_o, vecs[i].data);
         end
         tick();
      end
      snap_ready_i = 1'b0;

      // Sample while busy is dropped, not queued.
      $display("[TB] drop while busy");
      sample_i = 1'b1;
      tick();
      checkOutput("busy_drop_c1", 64'(drop_o), 64'd0);
      tick();
      sample_i = 1'b1;
      checkOutput("busy_drop_c2", 64'(drop_o), 64'd0);
      tick();
      checkOutput("busy_drop_c3", 64'(drop_o), 64'd1);
      tick();
      checkOutput("busy_drop_c4", 64'(drop_o), 64'd0);
      tick();
      checkOutput("busy_drop_count", 64'(snap_count_o), 64'd1);
      repeat (6) tick();
      checkOutput("busy_drop_single", 64'(snap_count_o), 64'd1);
      drain();
      checkOutput("drain_count", 64'(snap_count_o), 64'd0);

      // Fill the FIFO, then overflow attempt, then pop in order.
      $display("[TB] fifo full");
      for (int k = 0; k < 4; k++) begin
         sample_i = 1'b1;
         acc[k]   = cyc;
         repeat (6) tick();
      end
      checkOutput("full_count", 64'(snap_count_o), 64'(DEPTH));
      sample_i = 1'b1;
      tick();
      checkOutput("full_drop",    64'(drop_o),    64'd1);
      checkOutput("full_no_req",  64'(cnt_req_o), 64'd0);
      checkOutput("full_no_busy", 64'(busy_o),    64'd0);
      tick();
      checkOutput("full_drop_end", 64'(drop_o),    64'd0);
      checkOutput("full_no_req2",  64'(cnt_req_o), 64'd0);
      snap_ready_i = 1'b1;
      for (int k = 0; k < 4; k++) begin
         checkOutput($sformatf("pop%0d_valid", k), 64'(snap_valid_o), 64'd1);
         checkOutput($sformatf("pop%0d_data", k),  snap_data_o,       cnt_at(acc[k] + 2));
         tick();
      end
      snap_ready_i = 1'b0;
      checkOutput("pop_empty_count", 64'(snap_count_o), 64'd0);
      checkOutput("pop_empty_valid", 64'(snap_valid_o), 64'd0);

      // Counter that never answers.
      ack_en = 1'b0;
      sample_i = 1'b1;
`ifdef ATOMIC_COUNTER_READER_TIMEOUT_EN
      $display("[TB] timeout enabled");
      busy_low = 0;
      for (int c = 1; c <= 16; c++) begin
         tick();
         if (!busy_o || timeout_o) busy_low++;
      end
      checkOutput("tmo_busy_c1_16", 64'(busy_low), 64'd0);
      tick();
      checkOutput("tmo_busy_c17",  64'(busy_o),       64'd0);
      checkOutput("tmo_pulse_c17", 64'(timeout_o),    64'd1);
      checkOutput("tmo_count",     64'(snap_count_o), 64'd0);
      tick();
      checkOutput("tmo_pulse_c18", 64'(timeout_o), 64'd0);
      ack_en = 1'b1;
`else
      $display("[TB] timeout disabled");
      busy_low = 0;
      for (int c = 1; c <= 100; c++) begin
         tick();
         if (!busy_o || timeout_o) busy_low++;
      end
      checkOutput("notmo_busy_100", 64'(busy_low), 64'd0);
      ack_en = 1'b1;
      reset  = 1'b0;
      tick();
      reset  = 1'b1;
      tick();
      checkOutput("notmo_recover_busy", 64'(busy_o), 64'd0);
`endif

      // Reset in WAIT_HI with a snapshot already queued, then a stray ack.
      $display("[TB] reset mid-sequence");
      sample_i = 1'b1;
      repeat (6) tick();
      checkOutput("rst_pre_count", 64'(snap_count_o), 64'd1);
      sample_i = 1'b1;
      repeat (4) tick();
      checkOutput("rst_pre_busy", 64'(busy_o), 64'd1);
      pre_count = 64'(snap_count_o);
      checkOutput("rst_pre_count2", pre_count, 64'd1);
      #2 reset = 1'b0;
      #1;
      checkAllZero("rst_mid");
      tick();
      reset      = 1'b1;
      cnt_ack_i  = 1'b1;
      cnt_data_i = 32'h1234_5678;
      checkOutput("rst_rel_busy", 64'(busy_o), 64'd0);
      tick();
      checkOutput("stray_count", 64'(snap_count_o), 64'd0);
      checkOutput("stray_busy",  64'(busy_o),       64'd0);
      t1       = cyc;
      sample_i = 1'b1;
      repeat (4) tick();
      checkOutput("post_rst_busy_c4",  64'(busy_o), 64'd1);
      tick();
      checkOutput("post_rst_busy_c5",  64'(busy_o),       64'd0);
      checkOutput("post_rst_valid_c5", 64'(snap_valid_o), 64'd1);
      checkOutput("post_rst_data_c5",  snap_data_o,       cnt_at(t1 + 2));
      drain();
      t0 = cyc;
      checkOutput("pre_rand_count", 64'(snap_count_o), 64'd0);

      $display("[TB] random traffic from cycle %0d", t0);
      applyStimulus(400);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
